// File: rtl/mos6502s_fetch_pkg.sv
// Shared types and helpers for the mos6502s instruction fetch buffer:
// assembler state encoding, legal instruction lengths and op_len clean-up.
package mos6502s_fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LEN   = 2'd1,
        S_OPER  = 2'd2,
        S_VALID = 2'd3
    } fetch_state_t;

    localparam logic [1:0] LEN_MIN = 2'd1;
    localparam logic [1:0] LEN_MAX = 2'd3;

    // A decoder output of 0 is not a legal length, so it is promoted to a
    // single-byte instruction; the mask keeps the result inside LEN_MAX.
    function automatic logic [1:0] sanitize_len(input logic [1:0] raw_len);
        logic [1:0] clean;
        clean = (raw_len == 2'd0) ? LEN_MIN : (raw_len & LEN_MAX);
        return clean;
    endfunction

endpackage

// File: rtl/mos6502s_fetch_fifo.sv
// DATA_W x DEPTH synchronous byte FIFO with first-word fall-through read
// data, occupancy count and a flush that empties it in one cycle.
module mos6502s_fetch_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];

    // Flush wins over any push or pop issued in the same cycle.
    assign do_push = push && !full && !flush && !rst;
    assign do_pop  = pop && !empty && !flush && !rst;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mos6502s_instruction_fetch_buffer.sv
// Prefetch queue plus instruction assembler: collects an opcode and its
// operand bytes from the fetch FIFO and hands them over with valid/ready.
module mos6502s_instruction_fetch_buffer
    import mos6502s_fetch_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                fill_valid,
    input  logic [DATA_W-1:0]   fill_data,
    output logic                fill_ready,
    input  logic [1:0]          op_len,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [DATA_W-1:0]   opcode,
    output logic [DATA_W-1:0]   operand_lo,
    output logic [DATA_W-1:0]   operand_hi,
    output logic [2*DATA_W-1:0] operand,
    output logic [1:0]          instr_len,
    output logic [CNT_W-1:0]    fifo_count
);

    fetch_state_t      state;
    logic [1:0]        rem;
    logic              idx;
    logic [1:0]        len_clean;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;

    mos6502s_fetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (fill_valid),
        .push_data (fill_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fill_ready = !fifo_full;
    assign operand    = {operand_hi, operand_lo};
    assign len_clean  = sanitize_len(op_len);

    // Only the assembler pops; a flush cancels whatever pop it would issue.
    always_comb begin
        fifo_pop = 1'b0;
        if (!flush) begin
            case (state)
                S_FETCH: fifo_pop = !fifo_empty;
                S_OPER:  fifo_pop = !fifo_empty;
                S_VALID: fifo_pop = instr_ready && !fifo_empty;
                default: fifo_pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            instr_valid <= 1'b0;
            opcode      <= '0;
            operand_lo  <= '0;
            operand_hi  <= '0;
            instr_len   <= LEN_MIN;
            rem         <= 2'd0;
            idx         <= 1'b0;
        end else if (flush) begin
            state       <= S_FETCH;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fifo_pop) begin
                        opcode     <= fifo_data;
                        operand_lo <= '0;
                        operand_hi <= '0;
                        state      <= S_LEN;
                    end
                end
                S_LEN: begin
                    instr_len <= len_clean;
                    rem       <= len_clean - 2'd1;
                    idx       <= 1'b0;
                    if (len_clean == LEN_MIN) begin
                        state       <= S_VALID;
                        instr_valid <= 1'b1;
                    end else begin
                        state <= S_OPER;
                    end
                end
                S_OPER: begin
                    if (fifo_pop) begin
                        if (!idx) begin
                            operand_lo <= fifo_data;
                        end else begin
                            operand_hi <= fifo_data;
                        end
                        idx <= 1'b1;
                        rem <= rem - 2'd1;
                        if (rem == 2'd1) begin
                            state       <= S_VALID;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                S_VALID: begin
                    // Popping the next opcode on acceptance avoids a bubble.
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (fifo_pop) begin
                            opcode     <= fifo_data;
                            operand_lo <= '0;
                            operand_hi <= '0;
                            state      <= S_LEN;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state       <= S_FETCH;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mos6502s_instruction_fetch_buffer.md
Name: mos6502s_instruction_fetch_buffer

Overview:
- Parametrised prefetch queue plus instruction assembler for the mos6502s core.
- The memory side pushes fetched bytes into a DEPTH-entry byte FIFO.
- The assembler pops an opcode and then 0–2 operand bytes. The count comes from op_len, supplied by the external opcode decoder, which is driven from the opcode output.
- A complete instruction is presented to the control unit with a valid/ready handshake. Supports pipeline flush on taken branch/jump/interrupt.

Parameters:
- DATA_W, 8, byte width of fetched data and of each operand register.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of fifo_count (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard FIFO contents and any partially assembled instruction.
- fill_valid  in  1  fill_data holds a fetched byte.
- fill_data  in  DATA_W  fetched byte.
- fill_ready  out  1  FIFO can accept a byte.
- op_len  in  2  instruction length in bytes (1..3) for the current opcode, from the external decoder.
- instr_valid  out  1  opcode/operands hold a complete instruction.
- instr_ready  in  1  consumer accepts the instruction.
- opcode  out  DATA_W  latched opcode.
- operand_lo  out  DATA_W  first operand byte.
- operand_hi  out  DATA_W  second operand byte.
- operand  out  2*DATA_W  {operand_hi, operand_lo}.
- instr_len  out  2  latched, sanitised length of the presented instruction.
- fifo_count  out  CNT_W  current FIFO occupancy.

Behaviour:
- Reset: FIFO empty (rd/wr pointers 0, fifo_count 0), FSM in S_FETCH, instr_valid 0; opcode, operand_lo, operand_hi 0; instr_len 1; fill_ready 1.
- FIFO push when fill_valid && fill_ready. fill_ready = (fifo_count != DEPTH), with no bypass when full.
- FIFO pop is driven only by the FSM.
- Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo DEPTH.
- FSM states:
  - S_FETCH: if FIFO non-empty, pop into opcode, clear operand_lo/operand_hi to 0, go to S_LEN. Otherwise stay.
  - S_LEN: sample op_len. Values 0 are treated as 1, so instr_len ∈ {1,2,3}. Latch instr_len and set rem = len-1. If len == 1, go to S_VALID; otherwise go to S_OPER with idx = 0.
  - S_OPER: if FIFO non-empty, pop into operand_lo (idx 0) or operand_hi (idx 1), idx++, rem--. When the pop consumes the last byte (rem == 1), go to S_VALID. On empty, stall in place.
  - S_VALID: instr_valid = 1 and all outputs stable.
    - instr_ready && FIFO non-empty: pop the next opcode (operands cleared) and go to S_LEN (back-to-back, no bubble).
    - instr_ready && FIFO empty: go to S_FETCH.
    - Otherwise hold.
- instr_valid is registered: high exactly in S_VALID.
- Latency with a pre-filled FIFO, counted from the first S_FETCH edge: instr_valid rises after 2 clocks for 1-byte, 3 for 2-byte, 4 for 3-byte instructions.
- Steady-state throughput with back-to-back instructions: len+1 cycles per instruction.
- flush (lower priority than rst, higher than everything else):
  - Pointers and count go to 0; the FSM goes to S_FETCH; instr_valid goes to 0.
  - A push in the same cycle is dropped.
  - opcode/operand/instr_len retain their values.
  - Applies identically mid-S_OPER and in S_VALID, whether or not instr_ready is asserted.
- rst mid-operation: same as the reset state, regardless of handshake.
- op_len is only sampled in S_LEN; changes elsewhere are ignored.

Decomposition:
- Package mos6502s_fetch_pkg holds:
  - fsm state enum (S_FETCH, S_LEN, S_OPER, S_VALID);
  - LEN_MIN = 1, LEN_MAX = 3;
  - the op_len sanitise function.
- One sub-module, mos6502s_fetch_fifo. It is a parametrised DATA_W × DEPTH synchronous FIFO with push/pop/full/empty/count and a flush input, and is instantiated once.

Test Plan:
- Reset, then push A9 05 (op_len=2 while opcode=A9) -> opcode=A9, operand_lo=05, operand_hi=00, instr_len=2; instr_valid rises 3 clocks after the FSM first sees the opcode.
- Push 4C 34 12, op_len=3, instr_ready held high -> operand=1234 for one cycle; then EA with op_len=1 -> back-to-back, opcode=EA, operand=0000, no bubble cycle.
- Fill 4 bytes with instr_ready low while in S_VALID -> fifo_count=4, fill_ready=0; fifth byte not accepted; raising instr_ready restores fill_ready next cycle.
- Push AD only (op_len=3), delay 5 cycles, then push 00 C0 -> FSM stalls in S_OPER; instr_valid only after C0 is popped, operand=C000.
- flush asserted while in S_OPER with 2 bytes queued and fill_valid=1 -> fifo_count=0, instr_valid=0, pushed byte lost; next pushed byte becomes the opcode.
- op_len=0 for opcode 00 -> treated as length 1: instr_len=1, instr_valid after 2 clocks; rst asserted during S_VALID -> all outputs at reset values next cycle.
